// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
// Word width, reset PC default and FSM state encoding.
// Imported by the fetch unit, its target helper and the bench.
package fetch_unit_pkg;

  localparam int WORD_W = 12;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 12'h000;

  // FSM state encoding kept as plain constants for legacy tooling.
  localparam logic [1:0] FETCH_IDLE   = 2'd0;
  localparam logic [1:0] FETCH_REQ    = 2'd1;
  localparam logic [1:0] FETCH_HALTED = 2'd2;
  localparam logic [1:0] FETCH_FAULT  = 2'd3;

  // Next sequential word address; wraps 12'hFFF -> 12'h000.
  function automatic word_t incWord(input word_t a);
    return a + word_t'(1);
  endfunction

endpackage

// File: rtl/fetch_mem_if.sv
// Instruction memory read handshake (request held until acknowledge).
// master = fetch unit, slave = instruction memory.
// Data is only meaningful in the cycle memAck is high.
interface fetch_mem_if;
  import fetch_unit_pkg::*;

  logic  memReq;
  word_t memAddr;
  logic  memAck;
  word_t memData;

  modport master (output memReq, output memAddr, input memAck, input memData);
  modport slave  (input memReq, input memAddr, output memAck, output memData);

endinterface

// File: rtl/fetch_target.sv
// Redirect target computation for branches and jumps.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module fetch_target
  import fetch_unit_pkg::*;
(
  input  logic  iIS_JUMP,
  input  logic  iIS_ABS,
  input  word_t iIMM,
  input  word_t iREG,
  input  word_t iPC,
  output word_t oTARGET
);

  // Jumps take the register operand (absolute or PC-relative); branches add the immediate.
  always_comb begin
    oTARGET = iPC + iIMM;
    if (iIS_JUMP) begin
      if (iIS_ABS) begin
        oTARGET = iREG;
      end else begin
        oTARGET = iPC + iREG;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, memory req/ack handshake, redirects, timeout fault.
// Latency: fetch edge N -> request from N+1; ack edge M -> valid strobe during M+1.
// Backpressure: request held until ack; fetch pulses outside IDLE are dropped.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC    = RESET_PC_DEFAULT,
  parameter int    ACK_TIMEOUT = 15
) (
  input  logic  iCLK,
  input  logic  iRESET,
  input  logic  iENABLE,
  input  logic  iFETCH,
  input  logic  iHALT,
  input  logic  iREDIRECT,
  input  logic  iIS_JUMP,
  input  logic  iIS_ABS,
  input  word_t iIMM,
  input  word_t iREG,
  fetch_mem_if.master mem,
  output word_t oINST,
  output logic  oINST_VALID,
  output word_t oPC,
  output word_t oLINK,
  output logic  oBUSY,
  output logic  oFAULT
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

  logic [1:0] state;
  word_t      pc;
  word_t      memAddr;
  logic       memReq;
  word_t      inst;
  logic       instValid;
  word_t      outPc;
  word_t      link;
  logic       busy;
  logic       fault;
  logic [7:0] waitCnt;
  logic       pending;
  word_t      pendTarget;
  word_t      target;

  // Target is relative to oPC: the redirecting instruction is the last one delivered.
  fetch_target uTarget (
    .iIS_JUMP (iIS_JUMP),
    .iIS_ABS  (iIS_ABS),
    .iIMM     (iIMM),
    .iREG     (iREG),
    .iPC      (outPc),
    .oTARGET  (target)
  );

  // Fetch FSM with all outputs registered.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state      <= FETCH_IDLE;
      pc         <= RESET_PC;
      memAddr    <= RESET_PC;
      memReq     <= 1'b0;
      inst       <= '0;
      instValid  <= 1'b0;
      outPc      <= RESET_PC;
      link       <= incWord(RESET_PC);
      busy       <= 1'b0;
      fault      <= 1'b0;
      waitCnt    <= '0;
      pending    <= 1'b0;
      pendTarget <= RESET_PC;
    end else begin
      instValid <= 1'b0;
      case (state)
        FETCH_IDLE: begin
          if (iHALT) begin
            state <= FETCH_HALTED;
          end else begin
            if (iREDIRECT) begin
              pc <= target;
            end
            // A same-cycle redirect steers the new request to the target.
            if (iFETCH && iENABLE) begin
              memAddr <= iREDIRECT ? target : pc;
              memReq  <= 1'b1;
              busy    <= 1'b1;
              waitCnt <= '0;
              state   <= FETCH_REQ;
            end
          end
        end
        FETCH_REQ: begin
          if (mem.memAck) begin
            memReq  <= 1'b0;
            busy    <= 1'b0;
            waitCnt <= '0;
            pending <= 1'b0;
            state   <= FETCH_IDLE;
            // A redirect seen while waiting makes the returning word stale.
            if (iREDIRECT) begin
              pc <= target;
            end else if (pending) begin
              pc <= pendTarget;
            end else begin
              inst      <= mem.memData;
              outPc     <= memAddr;
              link      <= incWord(memAddr);
              pc        <= incWord(memAddr);
              instValid <= 1'b1;
            end
          end else begin
            if (iREDIRECT) begin
              pending    <= 1'b1;
              pendTarget <= target;
            end
            waitCnt <= waitCnt + 8'd1;
            if (waitCnt + 8'd1 == TIMEOUT_CNT) begin
              fault  <= 1'b1;
              memReq <= 1'b0;
              busy   <= 1'b0;
              state  <= FETCH_FAULT;
            end
          end
        end
        FETCH_HALTED: begin
          state <= FETCH_HALTED;
        end
        default: begin
          state <= FETCH_FAULT;
        end
      endcase
    end
  end

  assign mem.memReq  = memReq;
  assign mem.memAddr = memAddr;
  assign oINST       = inst;
  assign oINST_VALID = instValid;
  assign oPC         = outPc;
  assign oLINK       = link;
  assign oBUSY       = busy;
  assign oFAULT      = fault;

endmodule
